// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned),
// prescaler clock-enable, double-buffered per-channel duty and top applied at the period boundary.
module pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          top_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       duty_wr,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic [CHANNELS-1:0]       pending,
  output logic [WIDTH-1:0]          count
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  dir_down;
  logic [WIDTH-1:0]      active_top;
  logic [WIDTH-1:0]      shadow      [CHANNELS];
  logic [WIDTH-1:0]      active_duty [CHANNELS];
  logic                  boundary_d;

  logic                  tick;
  logic                  boundary;
  logic [WIDTH-1:0]      next_count;
  logic                  next_dir;

  assign tick     = enable && (pre_cnt == prescale);
  // The boundary is the tick that returns the counter to zero, in either mode.
  assign boundary = tick && (next_count == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_count = count;
    next_dir   = dir_down;
    if (!center_mode) begin
      next_count = (count == active_top) ? '0 : count + WIDTH'(1);
      next_dir   = 1'b0;
    end else if (active_top == '0) begin
      next_count = '0;
      next_dir   = 1'b0;
    end else if (dir_down || (count == active_top)) begin
      next_count = count - WIDTH'(1);
      next_dir   = (count != WIDTH'(1));
    end else begin
      next_count = count + WIDTH'(1);
      next_dir   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt      <= '0;
      count        <= '0;
      dir_down     <= 1'b0;
      active_top   <= '0;
      pending      <= '0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      boundary_d   <= 1'b0;
      // NOTE: the duty arrays are a handful of flops, not a RAM, so they are reset
      // along with everything else; a true memory would be left unreset.
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i]      <= '0;
        active_duty[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (duty_wr[i]) shadow[i] <= duty_in[i*WIDTH +: WIDTH];
      end

      if (!enable) begin
        pre_cnt      <= '0;
        count        <= '0;
        dir_down     <= 1'b0;
        active_top   <= top_in;
        pending      <= duty_wr;
        pwm_out      <= '0;
        period_start <= 1'b0;
        boundary_d   <= 1'b0;
        for (int i = 0; i < CHANNELS; i++) active_duty[i] <= shadow[i];
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
        if (tick) begin
          count    <= next_count;
          dir_down <= next_dir;
        end
        if (boundary) active_top <= top_in;

        // A write landing on the boundary clk leaves the old shadow to be applied
        // and keeps pending set for the following period.
        for (int i = 0; i < CHANNELS; i++) begin
          if (boundary && pending[i]) active_duty[i] <= shadow[i];
          if (duty_wr[i])    pending[i] <= 1'b1;
          else if (boundary) pending[i] <= 1'b0;
          pwm_out[i] <= (count < active_duty[i]);
        end

        // Two stages so the pulse lines up with the first output of the new period.
        boundary_d   <= boundary;
        period_start <= boundary_d;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: edge/center modes, duty extremes, deferred duty
// updates, enable drop and mid-period reset, with hand-computed expectations.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          center_mode;
  logic [7:0]    prescale;
  logic [W-1:0]  top_in;
  logic [CH*W-1:0] duty_in;
  logic [CH-1:0] duty_wr;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic [CH-1:0] pending;
  logic [W-1:0]  count;

  int n_vec = 0;
  int n_err = 0;
  int ones [CH];
  int ps_ones;

  pwm_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .center_mode  (center_mode),
    .prescale     (prescale),
    .top_in       (top_in),
    .duty_in      (duty_in),
    .duty_wr      (duty_wr),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .pending      (pending),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks and settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_duty(input int ch, input logic [W-1:0] val);
    duty_in[ch*W +: W] = val;
    duty_wr = CH'(1) << ch;
    step(1);
    duty_wr = '0;
  endtask

  // Move to the next sample where period_start is high.
  task automatic wait_ps(input int budget);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!period_start && n < budget);
    check("period_start_seen", {31'd0, period_start}, 32'd1);
  endtask

  task automatic wait_count(input logic [W-1:0] v, input int budget);
    int n = 0;
    while (count != v && n < budget) begin
      step(1);
      n++;
    end
    check("count_reached", {16'd0, count}, {16'd0, v});
  endtask

  // Sample n consecutive clocks starting with the current one.
  task automatic window(input int n);
    for (int c = 0; c < CH; c++) ones[c] = 0;
    ps_ones = 0;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CH; c++) ones[c] += int'(pwm_out[c]);
      ps_ones += int'(period_start);
      step(1);
    end
  endtask

  localparam logic [W-1:0] CENTER_SEQ [16] =
    '{0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0};

  initial begin
    int pre_ones;
    rst_n       = 1'b0;
    enable      = 1'b0;
    center_mode = 1'b0;
    prescale    = '0;
    top_in      = '0;
    duty_in     = '0;
    duty_wr     = '0;
    step(2);
    check("rst_pwm",     {28'd0, pwm_out}, 32'd0);
    check("rst_ps",      {31'd0, period_start}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_count",   {16'd0, count}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Edge mode, top=9, duties 3 / 3 / 0 / 10 loaded while idle.
    top_in  = 16'd9;
    duty_in = {16'd10, 16'd0, 16'd3, 16'd3};
    duty_wr = 4'hF;
    step(1);
    duty_wr = '0;
    check("idle_pending_set", {28'd0, pending}, 32'hF);
    step(1);
    check("idle_pending_clr", {28'd0, pending}, 32'd0);
    enable = 1'b1;
    wait_ps(40);
    check("ps_count", {16'd0, count}, 32'd1);
    check("ps_pwm0",  {31'd0, pwm_out[0]}, 32'd1);
    window(30);
    check("edge_ch0_duty3",  ones[0], 9);
    check("edge_ch1_duty3",  ones[1], 9);
    check("edge_ch2_duty0",  ones[2], 0);
    check("edge_ch3_duty10", ones[3], 30);
    check("edge_ps_rate",    ps_ones, 3);

    // Mid-period write at count=4: ch1 3->7, ch2 0->65535.
    wait_count(16'd4, 20);
    duty_in[1*W +: W] = 16'd7;
    duty_in[2*W +: W] = 16'hFFFF;
    duty_wr = 4'b0110;
    step(1);
    duty_wr = '0;
    check("mid_pending", {28'd0, pending}, 32'b0110);
    pre_ones = 0;
    for (int k = 0; k < 20 && !period_start; k++) begin
      pre_ones += int'(pwm_out[1]);
      step(1);
    end
    check("old_duty_completes", pre_ones, 0);
    check("ps_after_mid_write", {31'd0, period_start}, 32'd1);
    check("mid_pending_clr", {28'd0, pending}, 32'd0);
    window(10);
    check("ch1_duty7",     ones[1], 7);
    check("ch2_duty65535", ones[2], 10);
    check("ch0_unchanged", ones[0], 3);

    // Write on the boundary clk is deferred by one extra period.
    wait_count(16'd9, 20);
    write_duty(1, 16'd5);
    check("bnd_count0",  {16'd0, count}, 32'd0);
    check("bnd_pending", {31'd0, pending[1]}, 32'd1);
    wait_ps(20);
    window(10);
    check("bnd_old_shadow", ones[1], 7);
    check("bnd_pending_clr", {31'd0, pending[1]}, 32'd0);
    window(10);
    check("bnd_new_applied", ones[1], 5);

    // Center mode, top=4, duty=2, prescale=1.
    enable = 1'b0;
    center_mode = 1'b1;
    prescale = 8'd1;
    top_in = 16'd4;
    write_duty(0, 16'd2);
    step(2);
    enable = 1'b1;
    wait_ps(100);
    for (int c = 0; c < CH; c++) ones[c] = 0;
    ps_ones = 0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("center_count_%0d", k), {16'd0, count}, {16'd0, CENTER_SEQ[k]});
      ones[0] += int'(pwm_out[0]);
      ps_ones += int'(period_start);
      step(1);
    end
    check("center_pwm_high", ones[0], 6);
    check("center_ps_rate",  ps_ones, 1);
    check("center_next_ps",  {31'd0, period_start}, 32'd1);

    // Enable low for 5 clk mid-period, reprogram, restart.
    step(5);
    enable = 1'b0;
    step(1);
    check("dis_pwm",   {28'd0, pwm_out}, 32'd0);
    check("dis_count", {16'd0, count}, 32'd0);
    check("dis_ps",    {31'd0, period_start}, 32'd0);
    center_mode = 1'b0;
    prescale = '0;
    top_in = 16'd9;
    write_duty(0, 16'd6);
    step(1);
    check("dis_pending_clr", {28'd0, pending}, 32'd0);
    step(2);
    enable = 1'b1;
    wait_ps(40);
    window(10);
    check("restart_ch0_duty6", ones[0], 6);
    check("restart_ch1_duty5", ones[1], 5);

    // Reset mid-period with a write pending.
    step(3);
    write_duty(0, 16'd2);
    check("pre_rst_pending", {31'd0, pending[0]}, 32'd1);
    rst_n = 1'b0;
    step(1);
    check("mrst_pwm",     {28'd0, pwm_out}, 32'd0);
    check("mrst_ps",      {31'd0, period_start}, 32'd0);
    check("mrst_pending", {28'd0, pending}, 32'd0);
    check("mrst_count",   {16'd0, count}, 32'd0);
    rst_n = 1'b1;
    window(20);
    check("post_rst_no_pulse", ones[0] + ones[1] + ones[2] + ones[3], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
